// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues one word request at a time to instruction memory
// and buffers returned {pc, instr} pairs for decode, with flush-on-redirect.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    input  logic                       stall,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DROP = 2'b10
    } state_t;

    state_t         state_r, state_s;
    logic [31:0]    fetch_pc_r, fetch_pc_s;
    logic           imem_req_r, imem_req_s;
    logic [31:0]    imem_addr_r, imem_addr_s;
    logic [CW-1:0]  count_r;
    logic [PW-1:0]  head_r, tail_r;
    logic [31:0]    pc_mem_r    [DEPTH];
    logic [31:0]    instr_mem_r [DEPTH];
    logic           push_s, pop_s;
    logic [31:0]    redir_pc_s;

    assign redir_pc_s = {redirect_pc[31:2], 2'b00};
    // Redirect outranks both queue operations; a response only lands while WAITing.
    assign push_s     = (state_r == WAIT) && imem_ack && !redirect;
    assign pop_s      = (count_r != CNT_ZERO) && !stall && !redirect;

    // Fetch FSM: next state, request handshake and fetch address
    always_comb begin
        state_s     = state_r;
        fetch_pc_s  = fetch_pc_r;
        imem_req_s  = imem_req_r;
        imem_addr_s = imem_addr_r;
        case (state_r)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_s = redir_pc_s;
                end else if (count_r < FULL_C) begin
                    state_s     = WAIT;
                    imem_req_s  = 1'b1;
                    imem_addr_s = fetch_pc_r;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    state_s    = IDLE;
                    imem_req_s = 1'b0;
                    if (redirect) begin
                        fetch_pc_s = redir_pc_s;
                    end else begin
                        fetch_pc_s = fetch_pc_r + 32'd4;
                    end
                end else if (redirect) begin
                    // The handshake stays up; its data will be thrown away.
                    state_s    = DROP;
                    fetch_pc_s = redir_pc_s;
                end else begin
                    state_s = WAIT;
                end
            end
            DROP: begin
                if (redirect) begin
                    fetch_pc_s = redir_pc_s;
                end else begin
                    fetch_pc_s = fetch_pc_r;
                end
                if (imem_ack) begin
                    state_s    = IDLE;
                    imem_req_s = 1'b0;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                state_s    = IDLE;
                imem_req_s = 1'b0;
            end
        endcase
    end

    // FSM and request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            fetch_pc_r  <= RESET_PC;
            imem_req_r  <= 1'b0;
            imem_addr_r <= RESET_PC;
        end else begin
            state_r     <= state_s;
            fetch_pc_r  <= fetch_pc_s;
            imem_req_r  <= imem_req_s;
            imem_addr_r <= imem_addr_s;
        end
    end

    // Occupancy count and head/tail pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= CNT_ZERO;
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
        end else if (redirect) begin
            count_r <= CNT_ZERO;
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Entry storage, written at the tail on each accepted response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= 32'h0000_0000;
                instr_mem_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            pc_mem_r[tail_r]    <= imem_addr_r;
            instr_mem_r[tail_r] <= imem_rdata;
        end
    end

    assign imem_req  = imem_req_r;
    assign imem_addr = imem_addr_r;
    assign count     = count_r;
    assign out_valid = (count_r != CNT_ZERO);
    assign out_pc    = pc_mem_r[head_r];
    assign out_instr = instr_mem_r[head_r];

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: the memory side is driven by hand from one
// initial block and every expected value is written out per step.
module tb_ifetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int tests;
    int fails;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: inputs set before the call are sampled at this edge; pulses then clear.
    task automatic cyc();
        @(posedge clk);
        #1;
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        redirect   = 1'b0;
    endtask

    task automatic ack_with(input logic [31:0] a);
        imem_ack   = 1'b1;
        imem_rdata = instr_of(a);
        cyc();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(imem_req),  32'h0);
        chk({tag, "_addr"},  imem_addr,      32'h0);
        chk({tag, "_count"}, 32'(count),     32'h0);
        chk({tag, "_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_pc"},    out_pc,         32'h0);
        chk({tag, "_instr"}, out_instr,      32'h0);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'hBAD0_BAD0;

        cyc();
        cyc();
        chk_reset_outputs("rst");

        // Fill with 1-cycle-latency acks while decode stalls
        rst = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill%0d_req", i),  32'(imem_req), 32'h1);
            chk($sformatf("fill%0d_addr", i), imem_addr,     32'(4 * i));
            ack_with(32'(4 * i));
            chk($sformatf("fill%0d_count", i), 32'(count), 32'(i + 1));
            cyc();
        end
        chk("full_req0", 32'(imem_req), 32'h0);
        chk("full_valid", 32'(out_valid), 32'h1);
        chk("full_head_pc", out_pc, 32'h0);
        chk("full_head_instr", out_instr, instr_of(32'h0));
        cyc();
        chk("full_req1", 32'(imem_req), 32'h0);
        chk("full_count", 32'(count), 32'h4);

        // Single pop from full, then refill to 0x10
        stall = 1'b0;
        cyc();
        stall = 1'b1;
        chk("pop_count", 32'(count), 32'h3);
        chk("pop_pc", out_pc, 32'h4);
        chk("pop_instr", out_instr, instr_of(32'h4));
        chk("pop_req_same", 32'(imem_req), 32'h0);
        cyc();
        chk("refill_req", 32'(imem_req), 32'h1);
        chk("refill_addr", imem_addr, 32'h10);
        ack_with(32'h10);
        chk("refill_count", 32'(count), 32'h4);

        // Redirect from IDLE: flush, no request in the redirect cycle
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        cyc();
        chk("idle_redir_count", 32'(count), 32'h0);
        chk("idle_redir_valid", 32'(out_valid), 32'h0);
        chk("idle_redir_req", 32'(imem_req), 32'h0);
        cyc();
        chk("r0_addr", imem_addr, 32'h0);
        ack_with(32'h0);
        cyc();
        ack_with(32'h4);
        cyc();
        chk("to8_req", 32'(imem_req), 32'h1);
        chk("to8_addr", imem_addr, 32'h8);

        // Redirect while waiting on 0x8; late ack is dropped
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        cyc();
        chk("drop_count", 32'(count), 32'h0);
        chk("drop_valid", 32'(out_valid), 32'h0);
        chk("drop_req_held", 32'(imem_req), 32'h1);
        chk("drop_addr_held", imem_addr, 32'h8);
        cyc();
        cyc();
        chk("drop_addr_held2", imem_addr, 32'h8);
        ack_with(32'h8);
        chk("drop_ack_count", 32'(count), 32'h0);
        chk("drop_ack_req", 32'(imem_req), 32'h0);
        cyc();
        chk("after_drop_addr", imem_addr, 32'h100);
        ack_with(32'h100);
        chk("after_drop_count", 32'(count), 32'h1);
        chk("after_drop_pc", out_pc, 32'h100);
        chk("after_drop_instr", out_instr, instr_of(32'h100));

        // Redirect together with ack and pop
        cyc();
        ack_with(32'h104);
        chk("pre_combo_count", 32'(count), 32'h2);
        cyc();
        chk("pre_combo_addr", imem_addr, 32'h108);
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        ack_with(32'h108);
        stall = 1'b1;
        chk("combo_count", 32'(count), 32'h0);
        chk("combo_valid", 32'(out_valid), 32'h0);
        chk("combo_req", 32'(imem_req), 32'h0);
        cyc();
        chk("combo_next_addr", imem_addr, 32'h200);
        ack_with(32'h200);
        chk("combo_pc", out_pc, 32'h200);

        // Asynchronous reset while WAITing with two entries
        cyc();
        ack_with(32'h204);
        cyc();
        chk("prerst_count", 32'(count), 32'h2);
        chk("prerst_req", 32'(imem_req), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        cyc();
        rst = 1'b1;
        cyc();
        chk("rerst_req", 32'(imem_req), 32'h1);
        chk("rerst_addr", imem_addr, 32'h0);
        ack_with(32'h0);
        chk("rerst_count", 32'(count), 32'h1);

        // Address wrap at the top of the space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cyc();
        cyc();
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        ack_with(32'hFFFF_FFFC);
        chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_addr1", imem_addr, 32'h0);
        ack_with(32'h0);
        chk("wrap_count", 32'(count), 32'h2);
        stall = 1'b0;
        cyc();
        stall = 1'b1;
        chk("wrap_pc1", out_pc, 32'h0);
        chk("wrap_instr1", out_instr, instr_of(32'h0));

        // Unaligned redirect landing on an ack
        chk("unal_pre_addr", imem_addr, 32'h4);
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        ack_with(32'h4);
        chk("unal_count", 32'(count), 32'h0);
        cyc();
        chk("unal_addr", imem_addr, 32'h100);
        ack_with(32'h100);
        chk("unal_pc", out_pc, 32'h100);

        // Ack arriving in IDLE is ignored
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        cyc();
        chk("idle_ack_count", 32'(count), 32'h1);
        chk("idle_ack_req", 32'(imem_req), 32'h1);
        chk("idle_ack_addr", imem_addr, 32'h104);
        chk("idle_ack_instr", out_instr, instr_of(32'h100));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
